// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes the 2-bit light code into lamps and checks sequence/dwell
// Ports: clk, rst_n (async active-low); light_in code (00 R, 01 G, 10 Y); clr clears
// err_sticky/cycle_count; lamp_* one-hot drives; err_* one-cycle pulses; err_sticky
// held OR of errors; dwell_count saturating phase length; cycle_count Yellow->Red count.
module traffic_light_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 200,
  parameter int CNT_W     = 8,
  parameter int CYC_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       light_in,
  input  logic             clr,
  output logic             lamp_red,
  output logic             lamp_green,
  output logic             lamp_yellow,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             err_sticky,
  output logic [CNT_W-1:0] dwell_count,
  output logic [CYC_W-1:0] cycle_count
);
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
  localparam logic [CNT_W-1:0] MIND = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAXD = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  state_t           r_state, w_state;
  logic [1:0]       r_prev;
  logic [CNT_W-1:0] r_dwell, w_dwell, w_dwell_inc;
  logic [CYC_W-1:0] r_cyc;
  logic             r_red, r_green, r_yellow, r_err_code, r_err_seq, r_err_dwell, r_sticky;
  logic             w_code, w_same, w_step, w_err_seq, w_err_dwell, w_inc;
  assign w_code      = light_in == 2'b11;
  assign w_same      = light_in == r_prev;
  assign w_step      = (r_prev == 2'b00 && light_in == 2'b01) ||
                       (r_prev == 2'b01 && light_in == 2'b10) ||
                       (r_prev == 2'b10 && light_in == 2'b00);
  assign w_dwell_inc = &r_dwell ? r_dwell : r_dwell + ONE;
  always_comb begin
    w_state     = r_state;
    w_dwell     = r_dwell;
    w_err_seq   = 1'b0;
    w_err_dwell = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      IDLE: if (!w_code) begin
        w_state = TRACK;
        w_dwell = ONE;
      end
      TRACK: if (w_code) begin
        w_state = FAULT;
        w_dwell = ONE;
      end else if (w_same) begin
        w_dwell     = w_dwell_inc;
        // fires once: only on the sample that moves the count past MAX_DWELL
        w_err_dwell = r_dwell == MAXD;
      end else if (w_step) begin
        w_dwell     = ONE;
        w_err_dwell = r_dwell < MIND;
        w_inc       = r_prev == 2'b10;
      end else begin
        w_state   = FAULT;
        w_dwell   = ONE;
        w_err_seq = 1'b1;
      end
      FAULT: if (light_in == 2'b00) begin
        w_state = TRACK;
        w_dwell = ONE;
      end else begin
        w_dwell = w_same ? w_dwell_inc : ONE;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prev      <= 2'b00;
      r_dwell     <= '0;
      r_cyc       <= '0;
      r_red       <= 1'b1;
      r_green     <= 1'b0;
      r_yellow    <= 1'b0;
      r_err_code  <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_dwell <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_prev      <= light_in;
      r_dwell     <= w_dwell;
      r_cyc       <= clr ? '0 : r_cyc + CYC_W'(w_inc);
      // an invalid code falls back to red
      r_red       <= light_in == 2'b00 || w_code;
      r_green     <= light_in == 2'b01;
      r_yellow    <= light_in == 2'b10;
      r_err_code  <= w_code;
      r_err_seq   <= w_err_seq;
      r_err_dwell <= w_err_dwell;
      r_sticky    <= w_code | w_err_seq | w_err_dwell | (r_sticky & ~clr);
    end
  end
  assign lamp_red    = r_red;
  assign lamp_green  = r_green;
  assign lamp_yellow = r_yellow;
  assign err_code    = r_err_code;
  assign err_seq     = r_err_seq;
  assign err_dwell   = r_err_dwell;
  assign err_sticky  = r_sticky;
  assign dwell_count = r_dwell;
  assign cycle_count = r_cyc;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed checks of lamps, error pulses, dwell and cycle counts
module tb_traffic_light_monitor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  light_in;
  logic        clr;
  logic        a_red, a_green, a_yellow, a_code, a_seq, a_dwell, a_sticky;
  logic [7:0]  a_dcnt;
  logic [15:0] a_ccnt;
  logic        b_red, b_green, b_yellow, b_code, b_seq, b_dwell, b_sticky;
  logic [7:0]  b_dcnt;
  logic [15:0] b_ccnt;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  traffic_light_monitor u_a (
    .clk(clk), .rst_n(rst_n), .light_in(light_in), .clr(clr),
    .lamp_red(a_red), .lamp_green(a_green), .lamp_yellow(a_yellow),
    .err_code(a_code), .err_seq(a_seq), .err_dwell(a_dwell), .err_sticky(a_sticky),
    .dwell_count(a_dcnt), .cycle_count(a_ccnt)
  );
  traffic_light_monitor #(.MIN_DWELL(3), .MAX_DWELL(4)) u_b (
    .clk(clk), .rst_n(rst_n), .light_in(light_in), .clr(clr),
    .lamp_red(b_red), .lamp_green(b_green), .lamp_yellow(b_yellow),
    .err_code(b_code), .err_seq(b_seq), .err_dwell(b_dwell), .err_sticky(b_sticky),
    .dwell_count(b_dcnt), .cycle_count(b_ccnt)
  );
  task automatic step(input logic [1:0] c);
    light_in = c;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    checks++;
    if ({a_red, a_green, a_yellow} !== 3'b100) begin
      errors++;
      $display("FAIL reset_lamps got %b exp 100", {a_red, a_green, a_yellow});
    end
    checks++;
    if ({a_code, a_seq, a_dwell, a_sticky} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_errs got %b exp 0000", {a_code, a_seq, a_dwell, a_sticky});
    end
    checks++;
    if (a_dcnt !== 8'd0 || a_ccnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts got dwell %0d cycle %0d exp 0 0", a_dcnt, a_ccnt);
    end
  endtask
  task automatic test_sequence();
    logic [1:0] c;
    for (int i = 0; i < 30; i++) begin
      c = (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b01 : 2'b10;
      step(c);
      checks++;
      if ({a_red, a_green, a_yellow} !== {c == 2'b00, c == 2'b01, c == 2'b10}) begin
        errors++;
        $display("FAIL seq_lamps i=%0d got %b code %b", i, {a_red, a_green, a_yellow}, c);
      end
      checks++;
      if ({a_code, a_seq, a_dwell, a_sticky} !== 4'b0000) begin
        errors++;
        $display("FAIL seq_noerr i=%0d got %b exp 0000", i, {a_code, a_seq, a_dwell, a_sticky});
      end
      if (i == 27) begin
        checks++;
        if (a_ccnt !== 16'd9) begin
          errors++;
          $display("FAIL seq_cycles got %0d exp 9", a_ccnt);
        end
      end
    end
  endtask
  task automatic test_seq_err();
    step(2'b00);
    checks++;
    if (a_ccnt !== 16'd10) begin
      errors++;
      $display("FAIL seqerr_cyc_pre got %0d exp 10", a_ccnt);
    end
    step(2'b10);
    checks++;
    if ({a_seq, a_sticky, a_code} !== 3'b110) begin
      errors++;
      $display("FAIL seqerr_pulse got %b exp 110", {a_seq, a_sticky, a_code});
    end
    step(2'b01);
    checks++;
    if ({a_seq, a_dwell, a_code, a_green} !== 4'b0001) begin
      errors++;
      $display("FAIL fault_01 got %b exp 0001", {a_seq, a_dwell, a_code, a_green});
    end
    step(2'b10);
    checks++;
    if ({a_seq, a_dwell, a_code, a_yellow} !== 4'b0001) begin
      errors++;
      $display("FAIL fault_10 got %b exp 0001", {a_seq, a_dwell, a_code, a_yellow});
    end
    step(2'b00);
    checks++;
    if (a_ccnt !== 16'd10 || a_dcnt !== 8'd1 || a_seq !== 1'b0) begin
      errors++;
      $display("FAIL fault_exit got cyc %0d dwell %0d seq %b exp 10 1 0", a_ccnt, a_dcnt, a_seq);
    end
    step(2'b01);
    checks++;
    if ({a_seq, a_dwell, a_sticky} !== 3'b001) begin
      errors++;
      $display("FAIL track_resume got %b exp 001", {a_seq, a_dwell, a_sticky});
    end
  endtask
  task automatic test_code();
    for (int i = 0; i < 2; i++) begin
      step(2'b11);
      checks++;
      if ({a_red, a_green, a_yellow, a_code, a_seq} !== 5'b10010) begin
        errors++;
        $display("FAIL code11 i=%0d got %b exp 10010", i, {a_red, a_green, a_yellow, a_code, a_seq});
      end
    end
    step(2'b00);
    checks++;
    if ({a_code, a_seq, a_dcnt} !== {2'b00, 8'd1}) begin
      errors++;
      $display("FAIL code_exit got code %b seq %b dwell %0d exp 0 0 1", a_code, a_seq, a_dcnt);
    end
  endtask
  task automatic test_clr();
    clr = 1'b1;
    step(2'b10);
    checks++;
    if ({a_seq, a_sticky} !== 2'b11 || a_ccnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_vs_err got seq %b sticky %b cyc %0d exp 1 1 0", a_seq, a_sticky, a_ccnt);
    end
    step(2'b01);
    checks++;
    if (a_sticky !== 1'b0) begin
      errors++;
      $display("FAIL clr_sticky got %b exp 0", a_sticky);
    end
    clr = 1'b0;
    step(2'b00);
    step(2'b01);
    step(2'b10);
    clr = 1'b1;
    step(2'b00);
    checks++;
    if (a_ccnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_vs_inc got %0d exp 0", a_ccnt);
    end
    clr = 1'b0;
    step(2'b01);
    step(2'b10);
    step(2'b00);
    checks++;
    if (a_ccnt !== 16'd1) begin
      errors++;
      $display("FAIL cyc_after_clr got %0d exp 1", a_ccnt);
    end
  endtask
  task automatic test_reset_mid();
    step(2'b11);
    step(2'b00);
    step(2'b01);
    step(2'b01);
    checks++;
    if (a_sticky !== 1'b1 || a_dcnt !== 8'd2) begin
      errors++;
      $display("FAIL pre_rst got sticky %b dwell %0d exp 1 2", a_sticky, a_dcnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_red, a_green, a_yellow, a_sticky} !== 4'b1000 || a_dcnt !== 8'd0 || a_ccnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst got lamps/sticky %b dwell %0d cyc %0d exp 1000 0 0",
               {a_red, a_green, a_yellow, a_sticky}, a_dcnt, a_ccnt);
    end
    rst_n = 1'b1;
    step(2'b01);
    checks++;
    if ({a_green, a_seq} !== 2'b10 || a_dcnt !== 8'd1) begin
      errors++;
      $display("FAIL idle_exit got green %b seq %b dwell %0d exp 1 0 1", a_green, a_seq, a_dcnt);
    end
  endtask
  task automatic test_min_dwell();
    do_reset();
    step(2'b00);
    step(2'b00);
    step(2'b01);
    checks++;
    if (b_dwell !== 1'b1 || b_dcnt !== 8'd1 || a_dwell !== 1'b0) begin
      errors++;
      $display("FAIL min_short got b %b dwell %0d a %b exp 1 1 0", b_dwell, b_dcnt, a_dwell);
    end
    step(2'b01);
    step(2'b01);
    step(2'b10);
    checks++;
    if (b_dwell !== 1'b0 || b_dcnt !== 8'd1) begin
      errors++;
      $display("FAIL min_ok got err %b dwell %0d exp 0 1", b_dwell, b_dcnt);
    end
    step(2'b10);
    step(2'b10);
  endtask
  task automatic test_max_dwell();
    for (int i = 1; i <= 3; i++) step(2'b00);
    checks++;
    if (b_dwell !== 1'b0 || b_dcnt !== 8'd3) begin
      errors++;
      $display("FAIL max_pre got err %b dwell %0d exp 0 3", b_dwell, b_dcnt);
    end
    for (int i = 1; i <= 8; i++) begin
      step(2'b01);
      checks++;
      if (b_dwell !== (i == 5) || b_dcnt !== 8'(i)) begin
        errors++;
        $display("FAIL max_hold i=%0d got err %b dwell %0d exp %b %0d", i, b_dwell, b_dcnt, i == 5, i);
      end
    end
    checks++;
    if (b_sticky !== 1'b1 || b_seq !== 1'b0) begin
      errors++;
      $display("FAIL max_sticky got sticky %b seq %b exp 1 0", b_sticky, b_seq);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    light_in = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_sequence();
    test_seq_err();
    test_code();
    test_clr();
    test_reset_mid();
    test_min_dwell();
    test_max_dwell();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
